// File: rtl/vga_sync_receiver.sv
// VGA receive-side timing checker and active-pixel tap. Define FRAME_CHECKSUM_EN
// to add the per-frame R+G+B checksum output FRAME_SUM.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PIX_EN,
    input  logic        HS_N,
    input  logic        VS_N,
    input  logic        BLANK_N,
    input  logic [23:0] RGB_IN,
    output logic        PIX_VALID,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [23:0] PIX_RGB,
    output logic        FRAME_START,
    output logic        LOCKED,
    output logic        TIMING_ERR,
`ifdef FRAME_CHECKSUM_EN
    output logic [15:0] FRAME_SUM,
`endif
    output logic [9:0]  LINE_LEN
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] val, input logic [9:0] lim);
        return (val >= lim) ? lim : val + 10'd1;
    endfunction

    function automatic logic [9:0] sat_coord(input logic [9:0] val, input logic [9:0] lim);
        return (val >= lim) ? lim - 10'd1 : val;
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  good_cnt, good_nxt;
    logic        frame_bad, frame_bad_nxt;

    logic        vld_p0;
    logic        hs_p0, vs_p0, hs_prev_p0, vs_prev_p0, blank_p0;
    logic [23:0] rgb_p0;

    logic [9:0]  h_cnt, v_cnt, x_cnt, y_cnt;
    logic        h_seen, line_act, x_ovf, y_ovf;

    logic        hs_fall, vs_fall, active, checking, capture;
    logic [9:0]  h_cnt_inc, v_seen;
    logic        line_err, ovr_err, frame_err, x_err, y_err, err;

    // Stage p0: input sample on strobe; previous sample kept for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p0     <= 1'b0;
            hs_p0      <= 1'b0;
            vs_p0      <= 1'b0;
            hs_prev_p0 <= 1'b0;
            vs_prev_p0 <= 1'b0;
            blank_p0   <= 1'b0;
        end else begin
            vld_p0 <= PIX_EN;
            if (PIX_EN) begin
                hs_prev_p0 <= hs_p0;
                vs_prev_p0 <= vs_p0;
                hs_p0      <= HS_N;
                vs_p0      <= VS_N;
                blank_p0   <= BLANK_N;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (PIX_EN) rgb_p0 <= RGB_IN;
    end

    assign hs_fall   = vld_p0 & hs_prev_p0 & ~hs_p0;
    assign vs_fall   = vld_p0 & vs_prev_p0 & ~vs_p0;
    assign active    = vld_p0 & blank_p0;
    assign checking  = (state != ST_SEARCH);
    assign capture   = active & (state == ST_LOCKED);
    assign h_cnt_inc = h_cnt + 10'd1;
    // A VS fall coinciding with an HS fall still counts that line
    assign v_seen    = v_cnt + {9'd0, hs_fall};

    // h_seen gates line checks until a full line has been observed after SEARCH
    assign line_err  = hs_fall & h_seen & (h_cnt_inc != H_TOT);
    assign ovr_err   = vld_p0 & ~hs_fall & h_seen & (h_cnt == H_TOT - 10'd1);
    assign frame_err = vs_fall & (v_seen != V_TOT);
    assign x_err     = active & h_seen & ~x_ovf & (x_cnt >= H_ACT);
    assign y_err     = active & ~y_ovf & (y_cnt >= V_ACT);
    assign err       = checking & (line_err | ovr_err | frame_err | x_err | y_err);

    // Stage p1: raster counters, advanced once per strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            h_seen   <= 1'b0;
            line_act <= 1'b0;
            x_ovf    <= 1'b0;
            y_ovf    <= 1'b0;
            LINE_LEN <= '0;
        end else if (vld_p0) begin
            if (hs_fall) begin
                h_cnt    <= '0;
                LINE_LEN <= h_cnt_inc;
            end else begin
                h_cnt <= sat_inc(h_cnt, H_TOT);
            end

            if (vs_fall)      v_cnt <= '0;
            else if (hs_fall) v_cnt <= sat_inc(v_cnt, 10'h3ff);

            if (hs_fall)     x_cnt <= '0;
            else if (active) x_cnt <= sat_inc(x_cnt, H_ACT);

            if (hs_fall)     line_act <= 1'b0;
            else if (active) line_act <= 1'b1;

            if (vs_fall)                  y_cnt <= '0;
            else if (hs_fall && line_act) y_cnt <= sat_inc(y_cnt, V_ACT);

            if (hs_fall)                         x_ovf <= 1'b0;
            else if (active && x_cnt >= H_ACT)   x_ovf <= 1'b1;

            if (vs_fall)                         y_ovf <= 1'b0;
            else if (active && y_cnt >= V_ACT)   y_ovf <= 1'b1;

            if (hs_fall)        h_seen <= 1'b1;
            else if (!checking) h_seen <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_SEARCH;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            frame_bad <= frame_bad_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        good_nxt      = good_cnt;
        frame_bad_nxt = frame_bad;
        case (state)
            ST_SEARCH: begin
                good_nxt      = '0;
                frame_bad_nxt = 1'b0;
                if (vs_fall) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (err) begin
                    good_nxt      = '0;
                    frame_bad_nxt = ~vs_fall;
                end else if (vs_fall) begin
                    frame_bad_nxt = 1'b0;
                    if (frame_bad) begin
                        good_nxt = '0;
                    end else if (good_cnt + 8'd1 >= LOCK_N) begin
                        good_nxt  = '0;
                        state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = good_cnt + 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (err) state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    assign LOCKED = (state == ST_LOCKED);

    // Stage p2: output register for captured pixels and status pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PIX_VALID   <= 1'b0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            PIX_RGB     <= '0;
            FRAME_START <= 1'b0;
            TIMING_ERR  <= 1'b0;
        end else begin
            PIX_VALID   <= capture;
            FRAME_START <= vs_fall;
            TIMING_ERR  <= err;
            if (capture) begin
                PIX_X   <= sat_coord(x_cnt, H_ACT);
                PIX_Y   <= sat_coord(y_cnt, V_ACT);
                PIX_RGB <= rgb_p0;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] sum_acc, sum_add, px_sum;

    assign px_sum  = 16'(rgb_p0[23:16]) + 16'(rgb_p0[15:8]) + 16'(rgb_p0[7:0]);
    assign sum_add = (active && checking) ? sum_acc + px_sum : sum_acc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_acc   <= '0;
            FRAME_SUM <= '0;
        end else if (vs_fall) begin
            FRAME_SUM <= sum_add;
            sum_acc   <= '0;
        end else begin
            sum_acc <= sum_add;
        end
    end
`endif

endmodule
